// File: rtl/seq_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_pattern_detector_pkg
// Brief   : Shared types and constants for the serial pattern detector:
//           configuration-FSM state encoding, power-on pattern defaults and
//           a length-legality helper.
// Revision: 1.0 - initial release
// ============================================================================
package seq_pattern_detector_pkg;

   // Configuration FSM: ARMED detects, ERROR parks until a legal load
   typedef enum logic [0:0] {
      ST_ARMED = 1'b0,
      ST_ERROR = 1'b1
   } cfg_state_e;

   // Power-on configuration: legacy fixed '101' overlapping detector
   localparam int unsigned SPD_DEF_PAT = 32'b101;
   localparam int          SPD_DEF_LEN = 3;
   localparam bit          SPD_DEF_OVL = 1'b1;

   // A programmed length is usable only if it is 1..max_len
   function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
      return (len != 0) && (len <= max_len);
   endfunction

endpackage : seq_pattern_detector_pkg
`default_nettype wire

// File: rtl/seq_pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones; synchronous clear wins over
//           a same-cycle increment.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear first, then increment unless already saturated
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !(&count_q)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module  : seq_pattern_detector
// Brief   : Runtime-programmable serial bit-pattern detector with overlap
//           control, input enable, registered match pulse and saturating
//           match counter.
// Revision: 1.0 - initial release
// ============================================================================
module seq_pattern_detector
   import seq_pattern_detector_pkg::*;
#(
   parameter int               PAT_W   = 8,
   parameter int               CNT_W   = 16,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SPD_DEF_PAT),
   parameter int               DEF_LEN = SPD_DEF_LEN,
   parameter bit               DEF_OVL = SPD_DEF_OVL,
   localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             cfg_err
);

   localparam logic [LEN_W-1:0] C_MAX_FILL = LEN_W'(PAT_W);

   // Registered state
   cfg_state_e       state_q,   state_d;
   logic [PAT_W-1:0] pat_q,     pat_d;
   logic [LEN_W-1:0] len_q,     len_d;
   logic             ovl_q,     ovl_d;
   logic [PAT_W-1:0] hist_q,    hist_d;
   logic [LEN_W-1:0] fill_q,    fill_d;
   logic             match_q,   match_d;

   // Combinational helpers
   logic [PAT_W-1:0] w_mask;
   logic [PAT_W-1:0] w_hist_nx;
   logic [LEN_W-1:0] w_fill_inc;
   logic             w_shift;
   logic             w_hit;

   // Compare mask: only the low len bits of history take part
   for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign w_mask[gi] = (len_q > LEN_W'(gi));
   end

   // A bit is consumed only when valid, armed and not pre-empted by a load
   assign w_shift    = en && (state_q == ST_ARMED) && !cfg_load;
   assign w_hist_nx  = {hist_q[PAT_W-2:0], din};
   assign w_fill_inc = (fill_q == C_MAX_FILL) ? fill_q : fill_q + 1'b1;
   assign w_hit      = w_shift
                       && (w_fill_inc >= len_q)
                       && (((w_hist_nx ^ pat_q) & w_mask) == '0);

   // Next-state: config capture has priority, then shifting, else hold
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      if (cfg_load) begin
         pat_d   = cfg_pattern;
         len_d   = cfg_len;
         ovl_d   = cfg_overlap;
         hist_d  = '0;
         fill_d  = '0;
         state_d = len_legal(32'(cfg_len), PAT_W) ? ST_ARMED : ST_ERROR;
      end else if (w_shift) begin
         hist_d  = w_hist_nx;
         // Non-overlap: bits that formed a match may not seed the next one
         fill_d  = (w_hit && !ovl_q) ? '0 : w_fill_inc;
         match_d = w_hit;
      end
   end

   // State and datapath registers with asynchronous reset to defaults
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ARMED;
         pat_q   <= DEF_PAT;
         len_q   <= LEN_W'(DEF_LEN);
         ovl_q   <= DEF_OVL;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_hit),
      .clr_i   (cnt_clr),
      .count_o (match_count)
   );

   assign match   = match_q;
   assign cfg_err = (state_q == ST_ERROR);

endmodule : seq_pattern_detector
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_pattern_detector
// Brief   : Directed self-checking bench for seq_pattern_detector. Two
//           instances share stimulus: a 16-bit-counter one and a 2-bit-counter
//           one used for saturation. Expected match bits are queued when a
//           bit is driven and compared once the DUT has registered it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_pattern_detector;

   localparam int PAT_W = 8;
   localparam int LEN_W = $clog2(PAT_W + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             din = 1'b0;
   logic             cfg_load = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             cfg_overlap = 1'b0;
   logic             cnt_clr = 1'b0;

   logic             match_a, match_b;
   logic [15:0]      count_a;
   logic [1:0]       count_b;
   logic             err_a, err_b;

   int checks = 0;
   int errors = 0;

   logic  exp_q[$];
   string tag_q[$];

   seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr), .match(match_a), .match_count(count_a), .cfg_err(err_a)
   );

   seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cnt_clr(cnt_clr), .match(match_b), .match_count(count_b), .cfg_err(err_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expected match, compare after the edge
   task automatic step(input logic e, input logic d, input logic ld, input logic cc,
                       input logic exp_m, input string tag);
      logic  m;
      string t;
      @(negedge clk);
      en = e; din = d; cfg_load = ld; cnt_clr = cc;
      exp_q.push_back(exp_m);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         m = exp_q.pop_front();
         t = tag_q.pop_front();
         chk({t, "_match_a"}, 32'(match_a), 32'(m));
         chk({t, "_match_b"}, 32'(match_b), 32'(m));
      end
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                       input logic o, input string tag);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tag);
   endtask

   task automatic counts(input string tag, input logic [15:0] ea, input logic [1:0] eb);
      chk({tag, "_count_a"}, 32'(count_a), 32'(ea));
      chk({tag, "_count_b"}, 32'(count_b), 32'(eb));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_match", 32'(match_a), 32'd0);
      counts("rst", 16'd0, 2'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: default 101 overlapping
      step(1, 1, 0, 0, 0, "t1_b1");
      step(1, 0, 0, 0, 0, "t1_b2");
      step(1, 1, 0, 0, 1, "t1_b3");
      step(1, 0, 0, 0, 0, "t1_b4");
      step(1, 1, 0, 0, 1, "t1_b5");
      counts("t1", 16'd2, 2'd2);

      // 2: 101 non-overlapping
      load(8'h05, 4'd3, 1'b0, "t2_load");
      step(1, 1, 0, 0, 0, "t2_b1");
      step(1, 0, 0, 0, 0, "t2_b2");
      step(1, 1, 0, 0, 1, "t2_b3");
      step(1, 0, 0, 0, 0, "t2_b4");
      step(1, 1, 0, 0, 0, "t2_b5");
      counts("t2", 16'd3, 2'd3);

      // 3: 1101 overlapping
      load(8'h0D, 4'd4, 1'b1, "t3_load");
      step(1, 1, 0, 0, 0, "t3_b1");
      step(1, 1, 0, 0, 0, "t3_b2");
      step(1, 0, 0, 0, 0, "t3_b3");
      step(1, 1, 0, 0, 1, "t3_b4");
      step(1, 1, 0, 0, 0, "t3_b5");
      step(1, 0, 0, 0, 0, "t3_b6");
      step(1, 1, 0, 0, 1, "t3_b7");
      counts("t3", 16'd5, 2'd3);

      // 4: en gaps do not lose or duplicate bits
      load(8'h05, 4'd3, 1'b1, "t4_load");
      step(1, 1, 0, 0, 0, "t4_b1");
      step(0, 1, 0, 0, 0, "t4_g1");
      step(0, 1, 0, 0, 0, "t4_g2");
      step(0, 1, 0, 0, 0, "t4_g3");
      step(1, 0, 0, 0, 0, "t4_b2");
      step(0, 1, 0, 0, 0, "t4_g4");
      step(1, 1, 0, 0, 1, "t4_b3");
      step(0, 0, 0, 0, 0, "t4_idle");
      counts("t4", 16'd6, 2'd3);

      // 5: illegal lengths park in ERROR; legal load resumes
      load(8'h05, 4'd0, 1'b1, "t5_len0");
      chk("t5_err_len0", 32'(err_a), 32'd1);
      step(1, 1, 0, 0, 0, "t5_e1");
      step(1, 0, 0, 0, 0, "t5_e2");
      step(1, 1, 0, 0, 0, "t5_e3");
      counts("t5_frozen", 16'd6, 2'd3);
      load(8'h05, 4'd9, 1'b1, "t5_len9");
      chk("t5_err_len9", 32'(err_b), 32'd1);
      load(8'h05, 4'd3, 1'b1, "t5_len3");
      chk("t5_err_clear", 32'(err_a), 32'd0);
      step(1, 1, 0, 0, 0, "t5_b1");
      step(1, 0, 0, 0, 0, "t5_b2");
      step(1, 1, 0, 0, 1, "t5_b3");
      counts("t5", 16'd7, 2'd3);

      // 6: saturation held; clear beats a same-cycle hit
      step(1, 0, 0, 0, 0, "t6_b1");
      step(1, 1, 0, 1, 1, "t6_clr_hit");
      counts("t6_clr", 16'd0, 2'd0);
      step(1, 0, 0, 0, 0, "t6_b3");
      step(1, 1, 0, 0, 1, "t6_b4");
      counts("t6", 16'd1, 2'd1);

      // len=1, non-overlap: every matching bit hits
      load(8'h01, 4'd1, 1'b0, "l1_load");
      step(1, 1, 0, 0, 1, "l1_b1");
      step(1, 0, 0, 0, 0, "l1_b2");
      step(1, 1, 0, 0, 1, "l1_b3");
      step(1, 1, 0, 0, 1, "l1_b4");
      counts("l1", 16'd4, 2'd3);
      step(1, 0, 0, 0, 0, "l1_b5");

      // 7: async reset mid-stream restores defaults
      @(negedge clk);
      en = 1'b0;
      rst = 1'b1;
      #1;
      chk("t7_rst_match", 32'(match_a), 32'd0);
      counts("t7_rst", 16'd0, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 1, 0, 0, 0, "t7_b1");
      step(1, 0, 0, 0, 0, "t7_b2");
      step(1, 1, 0, 0, 1, "t7_b3");
      counts("t7", 16'd1, 2'd1);
      step(0, 0, 0, 0, 0, "t7_idle");

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_seq_pattern_detector
`default_nettype wire
